// File: rtl/rv_mem_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified-memory arbiter.
// Owner and state enums, default latency and counter width.
package rv_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam int MEM_LAT_DEF = 2;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; on a tie the port that did not
// win last time gets the grant. req[0] is IF, req[1] is data.
module rr_arb2
    import rv_mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic       valid,
    output owner_t     owner
);

    always_comb begin
        valid = |req;
        owner = OWN_IF;
        unique case (req)
            2'b11: owner = (last_owner == OWN_IF) ? OWN_D : OWN_IF;
            2'b10: owner = OWN_D;
            default: owner = OWN_IF;
        endcase
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Shares one fixed-latency single-port memory between IF and MEM ports.
// One access at a time: IDLE -> ACCESS (MEM_LAT+1 cycles) -> RESP.
module rv_mem_arbiter
    import rv_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [CNT_W-1:0] CNT_LAT = CNT_W'(MEM_LAT);

    state_t           state;
    owner_t           owner;
    owner_t           last_owner;
    logic [CNT_W-1:0] cnt;
    logic             sel_valid;
    owner_t           sel_owner;
    logic             sel_d;

    rr_arb2 u_arb (
        .req        ({d_req, if_req}),
        .last_owner (last_owner),
        .valid      (sel_valid),
        .owner      (sel_owner)
    );

    assign sel_d = (sel_owner == OWN_D);

    // mem_we/be/addr/wdata double as the access latches
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            last_owner <= OWN_IF;
            cnt        <= '0;
            if_gnt     <= 1'b0;
            if_done    <= 1'b0;
            if_rdata   <= '0;
            d_gnt      <= 1'b0;
            d_done     <= 1'b0;
            d_rdata    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_be     <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_en  <= 1'b0;
            if_done <= 1'b0;
            d_done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        owner      <= sel_owner;
                        last_owner <= sel_owner;
                        cnt        <= '0;
                        state      <= ACCESS;
                        mem_en     <= 1'b1;
                        mem_we     <= sel_d & d_we;
                        mem_be     <= sel_d ? d_be : 4'hF;
                        mem_addr   <= sel_d ? d_addr : if_addr;
                        mem_wdata  <= sel_d ? d_wdata : '0;
                        if_gnt     <= ~sel_d;
                        d_gnt      <= sel_d;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAT) begin
                        if (owner == OWN_IF) begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end else begin
                            if (!mem_we) d_rdata <= mem_rdata;
                            d_done <= 1'b1;
                        end
                        if_gnt    <= 1'b0;
                        d_gnt     <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_be    <= '0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        state     <= RESP;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
